// File: rtl/immenc_pkg.sv
// Shared types, opcodes and helpers for the RISC-V immediate encoder.
// The IMMENC_CHECK_EN build option is consumed by immenc_check and immenc.
package immenc_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4
    } imm_fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_FMT   = 2'd3
    } err_code_e;

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
    } req_t;

    // True when value[31:msb] are all equal, i.e. it sign-extends from bit msb.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned msb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << msb;
        return ((value & mask) == 32'h0000_0000) || ((value & mask) == mask);
    endfunction

    // Scatter the immediate and register fields into the format's bit layout.
    function automatic logic [31:0] pack_instr(input req_t r);
        logic [31:0] word;
        case (r.fmt)
            FMT_I:   word = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            FMT_S:   word = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
            FMT_B:   word = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                             r.imm[4:1], r.imm[11], r.opcode};
            FMT_U:   word = {r.imm[31:12], r.rd, r.opcode};
            FMT_J:   word = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/immenc_check.sv
// Combinational representability check of an immediate for its format.
// Range/alignment checks exist only when IMMENC_CHECK_EN is defined.
module immenc_check
    import immenc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        err,
    output logic [1:0]  code
);

    err_code_e code_s;

    // Bad format outranks misalignment, which outranks range.
    always_comb begin
        code_s = ERR_NONE;
        case (fmt)
`ifdef IMMENC_CHECK_EN
            FMT_I, FMT_S: begin
                if (!fits_signed(imm, 32'd11)) code_s = ERR_RANGE;
                else                           code_s = ERR_NONE;
            end
            FMT_B: begin
                if (imm[0])                         code_s = ERR_ALIGN;
                else if (!fits_signed(imm, 32'd12)) code_s = ERR_RANGE;
                else                                code_s = ERR_NONE;
            end
            FMT_U: begin
                if (imm[11:0] != 12'h000) code_s = ERR_RANGE;
                else                      code_s = ERR_NONE;
            end
            FMT_J: begin
                if (imm[0])                         code_s = ERR_ALIGN;
                else if (!fits_signed(imm, 32'd20)) code_s = ERR_RANGE;
                else                                code_s = ERR_NONE;
            end
`else
            FMT_I, FMT_S, FMT_B, FMT_U, FMT_J: code_s = ERR_NONE;
`endif
            default: code_s = ERR_FMT;
        endcase
    end

    assign code = code_s;
    assign err  = (code_s != ERR_NONE);

`ifndef IMMENC_CHECK_EN
    logic unused_imm_s;
    assign unused_imm_s = ^imm;
`endif

endmodule

// File: rtl/immenc.sv
// Two-stage RISC-V instruction encoder with valid/ready on both sides.
// IMMENC_CHECK_EN enables range/alignment checks and the error counter.
module immenc
    import immenc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [31:0]      in_imm,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [1:0]       out_err_code,
    output logic [CNT_W-1:0] out_err_cnt
);

    req_t        in_req_s;
    logic        chk_err_s;
    logic [1:0]  chk_code_s;

    req_t        s1_req_r;
    logic        s1_valid_r;
    logic        s1_err_r;
    logic [1:0]  s1_code_r;

    logic        s2_valid_r;
    logic [31:0] s2_instr_r;
    logic        s2_err_r;
    logic [1:0]  s2_code_r;

    logic        s1_advance_s;
    logic        s2_advance_s;

    assign in_req_s = '{fmt: in_fmt, imm: in_imm, opcode: in_opcode, rd: in_rd,
                        rs1: in_rs1, rs2: in_rs2, funct3: in_funct3};

    immenc_check u_check (
        .fmt  (in_fmt),
        .imm  (in_imm),
        .err  (chk_err_s),
        .code (chk_code_s)
    );

    assign s2_advance_s = !s2_valid_r || out_ready;
    assign s1_advance_s = !s1_valid_r || s2_advance_s;
    assign in_ready     = s1_advance_s;

    // Stage 1: capture the request together with its check result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_req_r   <= '0;
            s1_err_r   <= 1'b0;
            s1_code_r  <= 2'd0;
        end else if (s1_advance_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_req_r  <= in_req_s;
                s1_err_r  <= chk_err_s;
                s1_code_r <= chk_code_s;
            end
        end
    end

    // Stage 2: packed word; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_instr_r <= 32'h0000_0000;
            s2_err_r   <= 1'b0;
            s2_code_r  <= 2'd0;
        end else if (s2_advance_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_instr_r <= pack_instr(s1_req_r);
                s2_err_r   <= s1_err_r;
                s2_code_r  <= s1_code_r;
            end
        end
    end

    assign out_valid    = s2_valid_r;
    assign out_instr    = s2_instr_r;
    assign out_err      = s2_err_r;
    assign out_err_code = s2_code_r;

`ifdef IMMENC_CHECK_EN
    logic [CNT_W-1:0] err_cnt_r;

    // Count erroring words as they are handed off, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (s2_valid_r && out_ready && s2_err_r && (err_cnt_r != {CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_err_cnt = err_cnt_r;
`else
    assign out_err_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_immenc.sv
// Self-checking bench for immenc: directed cases, backpressure, reset, random round-trip.
module tb_immenc;
    import immenc_pkg::*;

    localparam int CNT_W = 16;
`ifdef IMMENC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [31:0]      in_imm;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [1:0]       out_err_code;
    logic [CNT_W-1:0] out_err_cnt;

    immenc #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_imm(in_imm), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .out_err_code(out_err_code), .out_err_cnt(out_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
    } tb_req_t;

    tb_req_t          q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] cnt_model = '0;
    bit               stall_pending = 1'b0;
    logic [31:0]      snap_instr;
    logic             snap_err;
    logic [1:0]       snap_code;

    function automatic tb_req_t mk(input logic [2:0] f, input logic [31:0] i, input logic [6:0] o,
                                   input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                   input logic [2:0] f3);
        tb_req_t r;
        r.fmt = f; r.imm = i; r.op = o; r.rd = d; r.rs1 = s1; r.rs2 = s2; r.f3 = f3;
        return r;
    endfunction

    function automatic longint pmod(input longint v, input longint m);
        longint x;
        x = v % m;
        if (x < 0) x = x + m;
        return x;
    endfunction

    // Two's-complement wrap of v into a signed field holding m distinct values.
    function automatic longint wrap(input longint v, input longint m);
        return pmod(v + m / 2, m) - m / 2;
    endfunction

    function automatic logic [1:0] model_code(input tb_req_t r);
        longint s;
        s = longint'($signed(r.imm));
        if (r.fmt > 3'd4) return 2'd3;
        if (!CHK) return 2'd0;
        case (r.fmt)
            3'd0, 3'd1: return (s < -2048 || s > 2047) ? 2'd1 : 2'd0;
            3'd2: begin
                if (pmod(s, 2) != 0) return 2'd2;
                return (s < -4096 || s > 4094) ? 2'd1 : 2'd0;
            end
            3'd3: return (pmod(s, 4096) != 0) ? 2'd1 : 2'd0;
            default: begin
                if (pmod(s, 2) != 0) return 2'd2;
                return (s < -1048576 || s > 1048574) ? 2'd1 : 2'd0;
            end
        endcase
    endfunction

    // Immediate the packed word should carry after truncation to the format.
    function automatic logic [31:0] model_imm(input tb_req_t r);
        longint s, w;
        s = longint'($signed(r.imm));
        case (r.fmt)
            3'd0, 3'd1: w = wrap(s, 4096);
            3'd2:       begin w = wrap(s, 8192); w = w - pmod(w, 2); end
            3'd3:       w = s - pmod(s, 4096);
            default:    begin w = wrap(s, 2097152); w = w - pmod(w, 2); end
        endcase
        return 32'(w);
    endfunction

    // Standard RISC-V immediate decoder.
    function automatic logic [31:0] immgen(input logic [2:0] f, input logic [31:0] i);
        case (f)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'h000};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic bit fields_ok(input tb_req_t r, input logic [31:0] w);
        bit ok;
        ok = (w[6:0] == r.op);
        if (r.fmt == 3'd0 || r.fmt == 3'd3 || r.fmt == 3'd4) ok = ok && (w[11:7] == r.rd);
        if (r.fmt <= 3'd2) ok = ok && (w[19:15] == r.rs1) && (w[14:12] == r.f3);
        if (r.fmt == 3'd1 || r.fmt == 3'd2) ok = ok && (w[24:20] == r.rs2);
        return ok;
    endfunction

    task automatic apply(input tb_req_t r);
        in_fmt = r.fmt; in_imm = r.imm; in_opcode = r.op; in_rd = r.rd;
        in_rs1 = r.rs1; in_rs2 = r.rs2; in_funct3 = r.f3;
    endtask

    task automatic check_out();
        tb_req_t    r;
        logic [1:0] ec;
        checks++;
        assert (q.size() != 0) else begin
            errors++; $error("FAIL unexpected_word obs=%h exp=none", out_instr);
        end
        if (q.size() != 0) begin
            r  = q.pop_front();
            ec = model_code(r);
            checks++;
            assert (out_err_code === ec) else begin
                errors++; $error("FAIL err_code fmt=%0d imm=%h obs=%0d exp=%0d", r.fmt, r.imm, out_err_code, ec);
            end
            checks++;
            assert (out_err === (ec != 2'd0)) else begin
                errors++; $error("FAIL err_flag fmt=%0d imm=%h obs=%0b exp=%0b", r.fmt, r.imm, out_err, ec != 2'd0);
            end
            if (ec == 2'd3) begin
                checks++;
                assert (out_instr === 32'h0) else begin
                    errors++; $error("FAIL badfmt_word obs=%h exp=00000000", out_instr);
                end
            end else begin
                checks++;
                assert (immgen(r.fmt, out_instr) === model_imm(r)) else begin
                    errors++; $error("FAIL round_trip fmt=%0d imm=%h obs=%h exp=%h", r.fmt, r.imm,
                                     immgen(r.fmt, out_instr), model_imm(r));
                end
                checks++;
                assert (fields_ok(r, out_instr) === 1'b1) else begin
                    errors++; $error("FAIL fields fmt=%0d obs=%h exp=op%h rd%0d rs1_%0d rs2_%0d f3_%0d",
                                     r.fmt, out_instr, r.op, r.rd, r.rs1, r.rs2, r.f3);
                end
            end
            if (ec != 2'd0 && cnt_model != {CNT_W{1'b1}}) cnt_model = cnt_model + 1'b1;
        end
    endtask

    // One clock: sample before the edge, record handshakes, then step past the edge.
    task automatic tick(output bit acc);
        bit emit, rst_now;
        #1;
        if (stall_pending) begin
            checks++;
            assert ({out_valid, out_instr, out_err, out_err_code} === {1'b1, snap_instr, snap_err, snap_code})
            else begin
                errors++; $error("FAIL stall_hold obs=%h exp=%h", {out_valid, out_instr, out_err, out_err_code},
                                 {1'b1, snap_instr, snap_err, snap_code});
            end
        end
        rst_now = (rst === 1'b1);
        acc  = !rst_now && (in_valid === 1'b1) && (in_ready === 1'b1);
        emit = !rst_now && (out_valid === 1'b1) && (out_ready === 1'b1);
        if (emit) check_out();
        if (acc) q.push_back(mk(in_fmt, in_imm, in_opcode, in_rd, in_rs1, in_rs2, in_funct3));
        stall_pending = !rst_now && (out_valid === 1'b1) && (out_ready !== 1'b1);
        snap_instr = out_instr; snap_err = out_err; snap_code = out_err_code;
        @(posedge clk);
        #1;
        if (rst_now) cnt_model = '0;
        checks++;
        assert (out_err_cnt === (CHK ? cnt_model : {CNT_W{1'b0}})) else begin
            errors++; $error("FAIL err_cnt obs=%0d exp=%0d", out_err_cnt, CHK ? cnt_model : {CNT_W{1'b0}});
        end
    endtask

    task automatic tick1();
        bit a;
        tick(a);
    endtask

    task automatic send(input tb_req_t r);
        bit a;
        apply(r);
        in_valid = 1'b1;
        tick(a);
        in_valid = 1'b0;
        checks++;
        assert (a === 1'b1) else begin errors++; $error("FAIL send_accept obs=%0b exp=1", a); end
    endtask

    function automatic tb_req_t rand_req();
        tb_req_t r;
        int k;
        k = int'($urandom_range(0, 19));
        r = mk(3'($urandom_range(0, 4)), 32'h0, 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom));
        case (r.fmt)
            3'd0, 3'd1: r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            3'd2:       r.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            3'd3:       r.imm = $urandom & 32'hFFFF_F000;
            default:    r.imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
        endcase
        if (k == 0) r.fmt = 3'($urandom_range(5, 7));
        if (k == 1) r.imm = $urandom;
        if (k == 2) r.imm = r.imm | 32'h1;
        return r;
    endfunction

    initial begin
        tb_req_t bp[3];
        tb_req_t r;
        bit      acc, pending;
        int      k;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        apply(mk(3'd0, 32'h0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0));
        tick1(); tick1();
        rst = 1'b0;
        checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_valid obs=%b exp=0", out_valid); end
        checks++; assert (out_instr === 32'h0) else begin errors++; $error("FAIL rst_instr obs=%h exp=0", out_instr); end
        checks++; assert ({out_err, out_err_code} === 3'b000) else begin
            errors++; $error("FAIL rst_err obs=%b%b exp=000", out_err, out_err_code); end
        checks++; assert (in_ready === 1'b1) else begin errors++; $error("FAIL rst_in_ready obs=%b exp=1", in_ready); end

        // I-type with exact latency.
        send(mk(3'd0, 32'hFFFF_FFFF, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0));
        checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL lat_early obs=%b exp=0", out_valid); end
        tick1();
        checks++; assert ({out_valid, out_instr, out_err} === {1'b1, 32'hFFF0_0093, 1'b0}) else begin
            errors++; $error("FAIL i_word obs=%b %h exp=1 fff00093", out_valid, out_instr); end
        tick1();
        send(mk(3'd1, 32'd8, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2));
        tick1();
        checks++; assert (out_instr === 32'h0020_A423) else begin errors++; $error("FAIL s_word obs=%h exp=0020a423", out_instr); end
        tick1();
        send(mk(3'd3, 32'h1234_5000, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0));
        tick1();
        checks++; assert (out_instr === 32'h1234_52B7) else begin errors++; $error("FAIL u_word obs=%h exp=123452b7", out_instr); end
        tick1();

        // Error cases.
        send(mk(3'd2, 32'd3, OP_BRANCH, 5'd0, 5'd3, 5'd4, 3'd1));
        tick1();
        checks++; assert ({out_err, out_err_code} === (CHK ? 3'b110 : 3'b000)) else begin
            errors++; $error("FAIL b_misalign obs=%b%b exp=%b", out_err, out_err_code, CHK ? 3'b110 : 3'b000); end
        tick1();
        send(mk(3'd4, 32'h0010_0000, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0));
        tick1();
        checks++; assert ({out_err, out_err_code} === (CHK ? 3'b101 : 3'b000)) else begin
            errors++; $error("FAIL j_range obs=%b%b exp=%b", out_err, out_err_code, CHK ? 3'b101 : 3'b000); end
        tick1();
        send(mk(3'd6, 32'h0000_0010, OP_IMM, 5'd7, 5'd7, 5'd7, 3'd7));
        tick1();
        checks++; assert ({out_err, out_err_code, out_instr} === {1'b1, 2'd3, 32'h0}) else begin
            errors++; $error("FAIL bad_fmt obs=%b %0d %h exp=1 3 0", out_err, out_err_code, out_instr); end
        tick1();
        checks++; assert (out_err_cnt === (CHK ? 16'd3 : 16'd0)) else begin
            errors++; $error("FAIL err_cnt3 obs=%0d exp=%0d", out_err_cnt, CHK ? 3 : 0); end

        // Backpressure: two accepts then stall, then in-order release.
        bp[0] = mk(3'd0, 32'd100, OP_IMM, 5'd10, 5'd11, 5'd0, 3'd1);
        bp[1] = mk(3'd2, 32'hFFFF_FFF0, OP_BRANCH, 5'd0, 5'd12, 5'd13, 3'd4);
        bp[2] = mk(3'd4, 32'd2048, OP_JAL, 5'd14, 5'd0, 5'd0, 3'd0);
        out_ready = 1'b0; k = 0;
        for (int c = 0; c < 4; c++) begin
            apply(bp[k]); in_valid = 1'b1;
            tick(acc);
            if (acc) k++;
        end
        checks++; assert (k == 2) else begin errors++; $error("FAIL bp_accepts obs=%0d exp=2", k); end
        #1;
        checks++; assert (in_ready === 1'b0) else begin errors++; $error("FAIL bp_in_ready obs=%b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 12 && (k < 3 || q.size() != 0); c++) begin
            if (k < 3) begin apply(bp[k]); in_valid = 1'b1; end else in_valid = 1'b0;
            tick(acc);
            if (acc) k++;
        end
        in_valid = 1'b0;
        checks++; assert (k == 3 && q.size() == 0) else begin
            errors++; $error("FAIL bp_drain obs=%0d/%0d exp=3/0", k, q.size()); end

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(mk(3'd7, 32'h0, OP_IMM, 5'd1, 5'd1, 5'd1, 3'd0));
        send(mk(3'd2, 32'd1, OP_BRANCH, 5'd1, 5'd1, 5'd1, 3'd0));
        rst = 1'b1;
        tick1();
        rst = 1'b0;
        q.delete();
        checks++; assert ({out_valid, out_err_cnt} === {1'b0, 16'd0}) else begin
            errors++; $error("FAIL midrst obs=%b %0d exp=0 0", out_valid, out_err_cnt); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick1();
            checks++; assert (out_valid === 1'b0) else begin errors++; $error("FAIL stale_word obs=%b exp=0", out_valid); end
        end

        // Random traffic with random backpressure.
        pending = 1'b0;
        for (int it = 0; it < 10000; it++) begin
            if (!pending) begin
                r = rand_req();
                apply(r);
                pending = ($urandom_range(0, 3) != 0);
                in_valid = pending;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) pending = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) tick1();
        tick1();
        checks++; assert (q.size() == 0) else begin errors++; $error("FAIL final_drain obs=%0d exp=0", q.size()); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/immenc.md
Name: immenc

Overview:
- Pipelined RISC-V instruction encoder: the inverse of the immediate decoder.
- Accepts a format select, a 32-bit signed immediate and register/function fields, and packs a legal 32-bit I/S/B/U/J instruction word.
- Checks that the immediate is representable in the selected format.
- Used by the self-test instruction generator and the boot-ROM patch path; feeds the fetch-side injection mux over a valid/ready link.

Parameters:
- CNT_W, 16, width of the saturating error counter (optional feature only).

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- in_fmt  input  3  format: 0=I, 1=S, 2=B, 3=U, 4=J; 5-7 illegal
- in_imm  input  32  signed immediate, byte offset for B/J, full value for U
- in_opcode  input  7  instr[6:0]
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  instr[14:12]
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts
- out_instr  output  32  encoded instruction
- out_err  output  1  immediate not representable, or illegal format
- out_err_code  output  2  0=none, 1=range, 2=misaligned, 3=bad format
- out_err_cnt  output  CNT_W  saturating error count (optional feature only)

Behaviour:
- Clocking and reset:
  - All state is on the posedge of clk.
  - While rst=1, both stage valids clear at the next edge.
  - After reset: out_valid=0, out_instr=0, out_err=0, out_err_code=0, out_err_cnt=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-operation drops in-flight words; nothing is emitted for them.
- Pipeline:
  - Two stages. S1 registers the request and the check result; S2 registers the packed word and error.
  - Latency is 2 cycles from the in_valid&&in_ready edge to out_valid, with no backpressure.
  - Throughput is 1 per cycle.
- Handshake:
  - A transfer occurs on valid&&ready at a clock edge.
  - Each stage advances when it is empty, or when the stage downstream advances that cycle.
  - in_ready = !s1_valid || s2_advance. It is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - out_valid, out_instr, out_err and out_err_code stay stable while out_valid && !out_ready.
  - At most 2 words are buffered; order is preserved.
- Packing: R = in_imm. Only the fields below are used; other fields are ignored.
  - I: {R[11:0], rs1, funct3, rd, opcode}
  - S: {R[11:5], rs2, rs1, funct3, R[4:0], opcode}
  - B: {R[12], R[10:5], rs2, rs1, funct3, R[4:1], R[11], opcode}
  - U: {R[31:12], rd, opcode}
  - J: {R[20], R[10:1], R[11], R[19:12], rd, opcode}
- Checks (priority: bad format > misaligned > range):
  - I/S: R[31:11] must all be equal.
  - B: R[0]=0 and R[31:12] all equal, i.e. range [-4096, 4094].
  - U: R[11:0] must be 0. A violation is code 1 (range).
  - J: R[0]=0 and R[31:20] all equal.
  - Illegal fmt: out_instr=0, code 3.
- Error output: on a range or misalign error the word is still packed from the truncated bits, and out_err=1.

Optional Feature:
- Macro: IMMENC_CHECK_EN.
- Defined:
  - Range and alignment checks active.
  - out_err_cnt increments by 1 on each accepted output (out_valid&&out_ready) with out_err=1, and saturates at all-ones.
- Undefined:
  - Only the bad-format check remains (code 3, instr=0). Codes 1 and 2 are never produced.
  - out_err_cnt is tied to 0.

Decomposition:
- Package immenc_pkg:
  - imm_fmt_e enum {FMT_I=0, FMT_S, FMT_B, FMT_U, FMT_J}; also adopted by the decoder select.
  - err_code_e enum {ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_FMT}.
  - Opcode constants OP_IMM=7'h13, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_LUI=7'h37, OP_JAL=7'h6F.
- One combinational sub-module, immenc_check: inputs fmt and imm, outputs err and code. It is instantiated in S1.

Test Plan:
- I-type, fmt=0, imm=32'hFFFFFFFF, opcode=13, rd=1, rs1=0, funct3=0 -> out_instr=32'hFFF00093, err=0, exactly 2 cycles later.
- S-type, fmt=1, imm=8, rs1=1, rs2=2, funct3=2, opcode=23 -> 32'h0020A423. U-type, fmt=3, imm=32'h12345000, rd=5, opcode=37 -> 32'h123452B7.
- Error cases:
  - B imm=3 -> err=1, code=2.
  - J imm=32'h00100000 -> code=1.
  - fmt=6 -> instr=0, code=3.
  - out_err_cnt=3 with IMMENC_CHECK_EN defined.
- Backpressure: hold out_ready=0 while offering 3 back-to-back requests -> in_ready drops after 2 accepts. Release out_ready -> all 3 emerge in order, outputs stable while stalled.
- Reset mid-operation: rst=1 for 1 cycle with both stages full -> out_valid=0 and out_err_cnt=0 next cycle, no stale word emitted afterwards.
- Round-trip: random legal fmt/imm through immenc, decode with immgen using the same select -> decoded immediate equals in_imm. 10k iterations.
